argon_mem_arbiter: RTL and testbench

//  Shares the single Argon memory port between two requesters: req0 = CPU core, req1 = debug/DMA master.

---
 rtl/argon_mem_pkg.sv | 41 ++++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/argon_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_argon_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argon_mem_pkg.sv
// Shared types and constants for the Argon memory arbiter.
//
// Contents:
//   RDMASK_*     3-bit read mask encodings (0 = no read)
//   WRMASK_*     2-bit write mask encodings (0 = no write)
//   arb_state_t  arbiter FSM states
//   mem_req_t    one latched memory request (address, write data, masks)
//
// ARGON_ADDR_W / ARGON_DATA_W size the request struct and are the default
// widths of the arbiter; the arbiter's ADDR_W/DATA_W should match them.
package argon_mem_pkg;

  localparam int ARGON_ADDR_W = 32;
  localparam int ARGON_DATA_W = 32;

  localparam logic [2:0] RDMASK_NONE = 3'd0;
  localparam logic [2:0] RDMASK_B    = 3'd1;
  localparam logic [2:0] RDMASK_BU   = 3'd2;
  localparam logic [2:0] RDMASK_H    = 3'd3;
  localparam logic [2:0] RDMASK_HU   = 3'd4;
  localparam logic [2:0] RDMASK_W    = 3'd5;

  localparam logic [1:0] WRMASK_NONE = 2'd0;
  localparam logic [1:0] WRMASK_B    = 2'd1;
  localparam logic [1:0] WRMASK_H    = 2'd2;
  localparam logic [1:0] WRMASK_W    = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    logic [ARGON_ADDR_W-1:0] addr;
    logic [ARGON_DATA_W-1:0] wr_data;
    logic [2:0]              rd_mask;
    logic [1:0]              wr_mask;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant.
//
// Ports:
//   valid      in   2  request valid per requester
//   last_grant in   1  index of the requester granted most recently
//   allow      in   2  requesters permitted to win (lock-owner mask)
//   grant      out  2  one-hot grant, all zero when nobody is eligible
module rr_arbiter2
  import argon_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic [1:0] allow,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  assign eligible = valid & allow;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/argon_mem_arbiter.sv
// Shares the single Argon memory port between the CPU core (req0) and the
// debug/DMA master (req1). Round-robin grant, one outstanding transaction,
// fixed memory read latency of MEM_LATENCY cycles.
//
// Optional feature: define ARGON_ARB_LOCK_EN to add the i_reqN_lock ports
// and bus locking for read-modify-write sequences.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready request handshake (N = 0,1)
//   i_reqN_addr/wr_data       request address and write data
//   i_reqN_rd_mask/wr_mask    read/write masks (0 = none)
//   i_reqN_lock               keep bus after this transfer (lock build only)
//   o_reqN_rsp_valid          one-cycle completion pulse
//   o_reqN_rd_data            read data, valid with rsp_valid, else 0
//   o_mem_*                   registered request towards memory
//   i_mem_rd_data             read data from memory
module argon_mem_arbiter
  import argon_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = ARGON_ADDR_W,
  parameter int DATA_W      = ARGON_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wr_data,
  input  logic [2:0]        i_req0_rd_mask,
  input  logic [1:0]        i_req0_wr_mask,
`ifdef ARGON_ARB_LOCK_EN
  input  logic              i_req0_lock,
`endif
  output logic              o_req0_rsp_valid,
  output logic [DATA_W-1:0] o_req0_rd_data,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wr_data,
  input  logic [2:0]        i_req1_rd_mask,
  input  logic [1:0]        i_req1_wr_mask,
`ifdef ARGON_ARB_LOCK_EN
  input  logic              i_req1_lock,
`endif
  output logic              o_req1_rsp_valid,
  output logic [DATA_W-1:0] o_req1_rd_data,

  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  output logic [2:0]        o_mem_rd_mask,
  output logic [1:0]        o_mem_wr_mask,
  input  logic [DATA_W-1:0] i_mem_rd_data
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [CNT_W-1:0]  lat_cnt;
  logic              last_grant;
  logic              grant_id;
  mem_req_t          req_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [1:0]        valid_vec;
  logic [1:0]        allow_vec;
  logic [1:0]        grant_vec;
  logic              accept;
  logic              winner;
  logic              last_busy;
  logic              idle_ok;

  assign valid_vec = {i_req1_valid, i_req0_valid};

`ifdef ARGON_ARB_LOCK_EN
  logic lock_active;
  logic lock_owner;
  logic xfer_lock;

  // While locked only the owner may be granted.
  assign allow_vec = lock_active ? (lock_owner ? 2'b10 : 2'b01) : 2'b11;
`else
  assign allow_vec = 2'b11;
`endif

  rr_arbiter2 u_rr (
    .valid      (valid_vec),
    .last_grant (last_grant),
    .allow      (allow_vec),
    .grant      (grant_vec)
  );

  // Ready is only offered in IDLE and never while reset is applied, so a
  // request presented during reset cannot appear accepted.
  assign idle_ok      = (state == ARB_IDLE) && !i_reset;
  assign o_req0_ready = idle_ok && grant_vec[0];
  assign o_req1_ready = idle_ok && grant_vec[1];
  assign accept       = o_req0_ready || o_req1_ready;
  assign winner       = grant_vec[1];
  assign last_busy    = (state == ARB_BUSY) && (lat_cnt == CNT_LAST);

  assign o_mem_addr    = ADDR_W'(req_q.addr);
  assign o_mem_wr_data = DATA_W'(req_q.wr_data);
  assign o_mem_rd_mask = req_q.rd_mask;
  assign o_mem_wr_mask = req_q.wr_mask;

  assign o_req0_rsp_valid = rsp_valid_q[0];
  assign o_req1_rsp_valid = rsp_valid_q[1];
  assign o_req0_rd_data   = rsp_valid_q[0] ? rsp_data_q : '0;
  assign o_req1_rd_data   = rsp_valid_q[1] ? rsp_data_q : '0;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: IDLE until an accept, BUSY for MEM_LATENCY cycles, one RESP.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (accept)    state_next = ARB_BUSY;
      ARB_BUSY: if (last_busy) state_next = ARB_RESP;
      ARB_RESP:                state_next = ARB_IDLE;
      default:                 state_next = ARB_IDLE;
    endcase
  end

  // Datapath: request latch, latency counter, response capture, lock state.
  // Response outputs are registered on the last BUSY edge so they line up
  // exactly with the RESP cycle, and the memory masks are dropped on that
  // same edge while address and write data are left holding.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lat_cnt     <= '0;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      req_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
`ifdef ARGON_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      xfer_lock   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 2'b00;

      if (accept) begin
        req_q.addr    <= ARGON_ADDR_W'(winner ? i_req1_addr    : i_req0_addr);
        req_q.wr_data <= ARGON_DATA_W'(winner ? i_req1_wr_data : i_req0_wr_data);
        req_q.rd_mask <= winner ? i_req1_rd_mask : i_req0_rd_mask;
        req_q.wr_mask <= winner ? i_req1_wr_mask : i_req0_wr_mask;
        last_grant    <= winner;
        grant_id      <= winner;
        lat_cnt       <= '0;
`ifdef ARGON_ARB_LOCK_EN
        xfer_lock     <= winner ? i_req1_lock : i_req0_lock;
`endif
      end

      if (state == ARB_BUSY) begin
        lat_cnt <= lat_cnt + CNT_W'(1);
        if (last_busy) begin
          rsp_valid_q   <= grant_id ? 2'b10 : 2'b01;
          rsp_data_q    <= (req_q.rd_mask != RDMASK_NONE) ? i_mem_rd_data : '0;
          req_q.rd_mask <= RDMASK_NONE;
          req_q.wr_mask <= WRMASK_NONE;
        end
      end

      if (state == ARB_RESP) begin
        rsp_data_q <= '0;
`ifdef ARGON_ARB_LOCK_EN
        // The lock takes effect, or is released, once the transfer finishes.
        lock_active <= xfer_lock;
        lock_owner  <= grant_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_argon_mem_arbiter.sv
// Directed testbench for argon_mem_arbiter. Two instances share the request
// inputs: dut_a with MEM_LATENCY=1 and dut_b with MEM_LATENCY=3.
// The lock scenario is compiled only when ARGON_ARB_LOCK_EN is defined.
module tb_argon_mem_arbiter;
  import argon_mem_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr;
  logic [31:0] req0_wr_data, req1_wr_data;
  logic [2:0]  req0_rd_mask, req1_rd_mask;
  logic [1:0]  req0_wr_mask, req1_wr_mask;
`ifdef ARGON_ARB_LOCK_EN
  logic        req0_lock, req1_lock;
`endif
  logic [31:0] mem_rd_data;

  logic        a_ready0, a_ready1, a_rsp0, a_rsp1;
  logic [31:0] a_rd0, a_rd1, a_addr, a_wdata;
  logic [2:0]  a_rmask;
  logic [1:0]  a_wmask;

  logic        b_ready0, b_ready1, b_rsp0, b_rsp1;
  logic [31:0] b_rd0, b_rd1, b_addr, b_wdata;
  logic [2:0]  b_rmask;
  logic [1:0]  b_wmask;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  argon_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_a (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_valid(req0_valid), .o_req0_ready(a_ready0),
    .i_req0_addr(req0_addr), .i_req0_wr_data(req0_wr_data),
    .i_req0_rd_mask(req0_rd_mask), .i_req0_wr_mask(req0_wr_mask),
`ifdef ARGON_ARB_LOCK_EN
    .i_req0_lock(req0_lock),
`endif
    .o_req0_rsp_valid(a_rsp0), .o_req0_rd_data(a_rd0),
    .i_req1_valid(req1_valid), .o_req1_ready(a_ready1),
    .i_req1_addr(req1_addr), .i_req1_wr_data(req1_wr_data),
    .i_req1_rd_mask(req1_rd_mask), .i_req1_wr_mask(req1_wr_mask),
`ifdef ARGON_ARB_LOCK_EN
    .i_req1_lock(req1_lock),
`endif
    .o_req1_rsp_valid(a_rsp1), .o_req1_rd_data(a_rd1),
    .o_mem_addr(a_addr), .o_mem_wr_data(a_wdata),
    .o_mem_rd_mask(a_rmask), .o_mem_wr_mask(a_wmask),
    .i_mem_rd_data(mem_rd_data)
  );

  argon_mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32), .DATA_W(32)) dut_b (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_valid(req0_valid), .o_req0_ready(b_ready0),
    .i_req0_addr(req0_addr), .i_req0_wr_data(req0_wr_data),
    .i_req0_rd_mask(req0_rd_mask), .i_req0_wr_mask(req0_wr_mask),
`ifdef ARGON_ARB_LOCK_EN
    .i_req0_lock(req0_lock),
`endif
    .o_req0_rsp_valid(b_rsp0), .o_req0_rd_data(b_rd0),
    .i_req1_valid(req1_valid), .o_req1_ready(b_ready1),
    .i_req1_addr(req1_addr), .i_req1_wr_data(req1_wr_data),
    .i_req1_rd_mask(req1_rd_mask), .i_req1_wr_mask(req1_wr_mask),
`ifdef ARGON_ARB_LOCK_EN
    .i_req1_lock(req1_lock),
`endif
    .o_req1_rsp_valid(b_rsp1), .o_req1_rd_data(b_rd1),
    .o_mem_addr(b_addr), .o_mem_wr_data(b_wdata),
    .o_mem_rd_mask(b_rmask), .o_mem_wr_mask(b_wmask),
    .i_mem_rd_data(mem_rd_data)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drives one requester's request fields.
  task automatic applyStimulus(input int idx, input logic valid,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] rmask, input logic [1:0] wmask,
                               input logic lock);
    if (idx == 0) begin
      req0_valid = valid; req0_addr = addr; req0_wr_data = wdata;
      req0_rd_mask = rmask; req0_wr_mask = wmask;
`ifdef ARGON_ARB_LOCK_EN
      req0_lock = lock;
`endif
    end else begin
      req1_valid = valid; req1_addr = addr; req1_wr_data = wdata;
      req1_rd_mask = rmask; req1_wr_mask = wmask;
`ifdef ARGON_ARB_LOCK_EN
      req1_lock = lock;
`endif
    end
    if (lock) begin
      // lock is only meaningful in the lock build
    end
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic resetDuts();
    i_reset = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    mem_rd_data = 32'h0;
    resetDuts();
    #1;
    checkOutput("rst_ready0", a_ready0, 0);
    checkOutput("rst_rsp0",   a_rsp0,   0);
    checkOutput("rst_rsp1",   a_rsp1,   0);
    checkOutput("rst_addr",   a_addr,   0);
    checkOutput("rst_rmask",  a_rmask,  0);
    checkOutput("rst_wmask",  a_wmask,  0);
    checkOutput("rst_rd0",    a_rd0,    0);

    // Single read by req0, latency 1.
    $display("[TB] read from req0");
    mem_rd_data = 32'hDEADBEEF;
    applyStimulus(0, 1'b1, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t1_ready0", a_ready0, 1);
    checkOutput("t1_ready1", a_ready1, 0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t1_addr",       a_addr,   32'h100);
    checkOutput("t1_rmask",      a_rmask,  RDMASK_W);
    checkOutput("t1_busy_ready", a_ready0, 0);
    checkOutput("t1_busy_rsp",   a_rsp0,   0);
    @(negedge clk); #1;
    checkOutput("t1_rsp0",       a_rsp0,   1);
    checkOutput("t1_rd0",        a_rd0,    32'hDEADBEEF);
    checkOutput("t1_rsp1",       a_rsp1,   0);
    checkOutput("t1_resp_rmask", a_rmask,  0);
    checkOutput("t1_resp_addr",  a_addr,   32'h100);
    @(negedge clk); #1;
    checkOutput("t1_rsp0_end",   a_rsp0,   0);
    checkOutput("t1_rd0_end",    a_rd0,    0);

    // Both requesters valid continuously: grants alternate every 3 cycles.
    $display("[TB] alternating grants");
    resetDuts();
    mem_rd_data = 32'h0BADF00D;
    applyStimulus(0, 1'b1, 32'h400, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    applyStimulus(1, 1'b1, 32'h404, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("t2_ready0_%0d", k), a_ready0, (k % 6) == 0);
      checkOutput($sformatf("t2_ready1_%0d", k), a_ready1, (k % 6) == 3);
      checkOutput($sformatf("t2_rsp0_%0d", k),   a_rsp0,   (k % 6) == 2);
      checkOutput($sformatf("t2_rsp1_%0d", k),   a_rsp1,   (k % 6) == 5);
      if ((k % 6) == 1) checkOutput($sformatf("t2_addr_%0d", k), a_addr, 32'h400);
      if ((k % 6) == 4) checkOutput($sformatf("t2_addr_%0d", k), a_addr, 32'h404);
    end

    // Write by req1: completes with rd_data 0.
    $display("[TB] write from req1");
    resetDuts();
    mem_rd_data = 32'hDEADBEEF;
    applyStimulus(1, 1'b1, 32'h200, 32'h12345678, RDMASK_NONE, WRMASK_W, 1'b0);
    #1;
    checkOutput("t3_ready1", a_ready1, 1);
    checkOutput("t3_ready0", a_ready0, 0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t3_wmask", a_wmask, 2'd3);
    checkOutput("t3_wdata", a_wdata, 32'h12345678);
    checkOutput("t3_addr",  a_addr,  32'h200);
    checkOutput("t3_rmask", a_rmask, 0);
    @(negedge clk); #1;
    checkOutput("t3_wmask_resp", a_wmask, 0);
    checkOutput("t3_rsp1",       a_rsp1,  1);
    checkOutput("t3_rd1",        a_rd1,   0);
    checkOutput("t3_rsp0",       a_rsp0,  0);
    checkOutput("t3_rd0",        a_rd0,   0);
    @(negedge clk); #1;
    checkOutput("t3_rsp1_end",   a_rsp1,  0);

    // Latency 3 instance: request held for 3 cycles, response on T+4.
    $display("[TB] latency 3 read");
    resetDuts();
    mem_rd_data = 32'hCAFEF00D;
    applyStimulus(0, 1'b1, 32'h300, 32'h0, RDMASK_H, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t4_ready0", b_ready0, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
      #1;
      checkOutput($sformatf("t4_addr_%0d", k),  b_addr,   32'h300);
      checkOutput($sformatf("t4_rmask_%0d", k), b_rmask,  RDMASK_H);
      checkOutput($sformatf("t4_rsp_%0d", k),   b_rsp0,   0);
      checkOutput($sformatf("t4_ready_%0d", k), b_ready0, 0);
    end
    @(negedge clk); #1;
    checkOutput("t4_rsp0",     b_rsp0, 1);
    checkOutput("t4_rd0",      b_rd0,  32'hCAFEF00D);
    checkOutput("t4_rsp1",     b_rsp1, 0);
    @(negedge clk); #1;
    checkOutput("t4_rsp0_end", b_rsp0, 0);

    // Reset while BUSY abandons the transfer.
    $display("[TB] reset during busy");
    resetDuts();
    mem_rd_data = 32'h55AA55AA;
    applyStimulus(0, 1'b1, 32'h500, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t5_ready0", a_ready0, 1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    i_reset = 1'b1;
    #1;
    checkOutput("t5_busy_addr", a_addr, 32'h500);
    @(negedge clk); #1;
    checkOutput("t5_rsp0",  a_rsp0,  0);
    checkOutput("t5_rd0",   a_rd0,   0);
    checkOutput("t5_addr",  a_addr,  0);
    checkOutput("t5_rmask", a_rmask, 0);
    i_reset = 1'b0;
    applyStimulus(0, 1'b1, 32'h510, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    applyStimulus(1, 1'b1, 32'h514, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t5_tie_ready0", a_ready0, 1);
    checkOutput("t5_tie_ready1", a_ready1, 0);

`ifdef ARGON_ARB_LOCK_EN
    // Locked read-modify-write by req0 keeps req1 waiting.
    $display("[TB] locked read-modify-write");
    resetDuts();
    mem_rd_data = 32'h11112222;
    applyStimulus(0, 1'b1, 32'h600, 32'h0, RDMASK_W, WRMASK_NONE, 1'b1);
    applyStimulus(1, 1'b1, 32'h700, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t6_ready0_k0", a_ready0, 1);
    checkOutput("t6_ready1_k0", a_ready1, 0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h600, 32'hABCD0000, RDMASK_NONE, WRMASK_W, 1'b0);
    #1;
    checkOutput("t6_busy_ready1", a_ready1, 0);
    @(negedge clk); #1;
    checkOutput("t6_rsp0_read", a_rsp0, 1);
    @(negedge clk); #1;
    checkOutput("t6_ready0_k3", a_ready0, 1);
    checkOutput("t6_ready1_k3", a_ready1, 0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h604, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
    #1;
    checkOutput("t6_wmask", a_wmask, 2'd3);
    checkOutput("t6_addr",  a_addr,  32'h600);
    @(negedge clk); #1;
    checkOutput("t6_rsp0_write", a_rsp0, 1);
    @(negedge clk); #1;
    checkOutput("t6_ready1_k6", a_ready1, 1);
    checkOutput("t6_ready0_k6", a_ready0, 0);
`endif

    applyStimulus(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
